sfx_scheduler: RTL and testbench

Sound-effect scheduler that shares one square-wave tone generator between four game-event requesters (bullet, hit, pickup, explosion). It latches request pulses and grants the highest-priority pending effect. Each effect is played as a short fixed note sequence, as `note_div` values of the existing tone-divider format. It sits between the game logic and the audio path, driving the SFX tone generator and a `duck` flag that the mixer uses to suppress background music.

---
 rtl/sfx_scheduler.sv | 151 +++++++++++++++
 tb/tb_sfx_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sfx_scheduler.sv
// Sound-effect scheduler: latches four request pulses and plays the highest-priority one
// as a short note sequence on the shared tone generator. Optional macro: SFX_PREEMPT_EN.
module sfx_scheduler #(
    parameter logic [23:0] NOTE_TICKS = 24'd2500000,
    parameter logic [23:0] GAP_TICKS  = 24'd500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sfx_en,
    input  logic [3:0]  req,
    output logic [21:0] note_div,
    output logic        tone_en,
    output logic [1:0]  active_id,
    output logic        duck,
    output logic [3:0]  pending
);

    // A zero length would never match the terminal count, so it behaves as 1.
    localparam logic [23:0] NOTE_LAST = (NOTE_TICKS == 24'd0) ? 24'd0 : NOTE_TICKS - 24'd1;
    localparam logic [23:0] GAP_LAST  = (GAP_TICKS  == 24'd0) ? 24'd0 : GAP_TICKS  - 24'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  pend_q,  pend_d;
    logic [1:0]  id_q,    id_d;
    logic [1:0]  idx_q,   idx_d;
    logic [23:0] tick_q,  tick_d;
    logic [3:0]  grant;

    function automatic logic [21:0] rom(input logic [1:0] id, input logic [1:0] idx);
        logic [21:0] v;
        case ({id, idx})
            4'b00_00: v = 22'd90000;
            4'b00_01: v = 22'd75000;
            4'b01_00: v = 22'd151515;
            4'b01_01: v = 22'd191571;
            4'b10_00: v = 22'd191571;
            4'b10_01: v = 22'd151515;
            4'b10_10: v = 22'd127551;
            4'b10_11: v = 22'd95602;
            4'b11_00: v = 22'd255102;
            4'b11_01: v = 22'd286344;
            4'b11_10: v = 22'd340530;
            4'b11_11: v = 22'd382234;
            default:  v = 22'd0;
        endcase
        return v;
    endfunction

    function automatic logic [1:0] top_id(input logic [3:0] p);
        logic [1:0] r;
        if (p[3])      r = 2'd3;
        else if (p[2]) r = 2'd2;
        else if (p[1]) r = 2'd1;
        else           r = 2'd0;
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        grant   = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (pend_q != 4'b0000) begin
                    state_d = S_PLAY;
                    id_d    = top_id(pend_q);
                    idx_d   = 2'd0;
                    tick_d  = 24'd0;
                    grant   = 4'b0001 << top_id(pend_q);
                end
            end
            S_PLAY: begin
`ifdef SFX_PREEMPT_EN
                if (pend_q != 4'b0000 && top_id(pend_q) > id_q) begin
                    id_d   = top_id(pend_q);
                    idx_d  = 2'd0;
                    tick_d = 24'd0;
                    grant  = 4'b0001 << top_id(pend_q);
                end else
`endif
                if (tick_q == NOTE_LAST) begin
                    tick_d = 24'd0;
                    // A zero slot ends the effect early, same as running off the last slot.
                    if (idx_q == 2'd3 || rom(id_q, 2'(idx_q + 2'd1)) == 22'd0) begin
                        state_d = S_GAP;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d   = 2'(idx_q + 2'd1);
                    end
                end else begin
                    tick_d = tick_q + 24'd1;
                end
            end
            S_GAP: begin
                if (tick_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    tick_d  = 24'd0;
                end else begin
                    tick_d  = tick_q + 24'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = 24'd0;
                idx_d   = 2'd0;
            end
        endcase

        // A new request on the granting edge survives the clear (re-pend of the same id).
        pend_d = (pend_q & ~grant) | req;

        if (!sfx_en) begin
            state_d = S_IDLE;
            pend_d  = 4'b0000;
            tick_d  = 24'd0;
            idx_d   = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= 4'b0000;
            id_q    <= 2'd0;
            idx_q   <= 2'd0;
            tick_q  <= 24'd0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            id_q    <= id_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
        end
    end

    assign tone_en   = (state_q == S_PLAY);
    assign note_div  = tone_en ? rom(id_q, idx_q) : 22'd0;
    assign duck      = (state_q != S_IDLE);
    assign active_id = id_q;
    assign pending   = pend_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: elapsed-time model of each effect plus directed literal checks.
module tb_sfx_scheduler;
    localparam int NT = 4;
    localparam int GT = 2;
`ifdef SFX_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif
    localparam int ROM [4][4] = '{'{90000, 75000, 0, 0},
                                  '{151515, 191571, 0, 0},
                                  '{191571, 151515, 127551, 95602},
                                  '{255102, 286344, 340530, 382234}};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sfx_en = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [21:0] note_div;
    logic        tone_en;
    logic [1:0]  active_id;
    logic        duck;
    logic [3:0]  pending;

    sfx_scheduler #(.NOTE_TICKS(24'(NT)), .GAP_TICKS(24'(GT))) dut (
        .clk(clk), .rst_n(rst_n), .sfx_en(sfx_en), .req(req),
        .note_div(note_div), .tone_en(tone_en), .active_id(active_id),
        .duck(duck), .pending(pending)
    );

    always #5 clk = ~clk;

    function automatic int nlen(input int id);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (ROM[id][k] == 0) done = 1'b1;
            if (!done) n++;
        end
        return n;
    endfunction

    function automatic int top(input logic [3:0] p);
        int r;
        r = 0;
        for (int k = 0; k < 4; k++) if (p[k]) r = k;
        return r;
    endfunction

    // Model: a granted effect is just an id plus cycles elapsed since its grant.
    logic [3:0] m_pend = 4'b0000;
    logic       m_busy = 1'b0;
    logic [1:0] m_id   = 2'd0;
    int         m_el   = 0;

    always begin
        logic [3:0] p;
        logic       b;
        logic [1:0] id;
        int         el;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pend = 4'b0000; m_busy = 1'b0; m_id = 2'd0; m_el = 0;
        end else if (!sfx_en) begin
            m_pend = 4'b0000; m_busy = 1'b0; m_el = 0;
        end else begin
            p = m_pend; b = m_busy; id = m_id; el = m_el;
            if (!b) begin
                if (p != 4'b0000) begin
                    id = 2'(top(p)); p[id] = 1'b0; b = 1'b1; el = 0;
                end
            end else if (PRE && el < nlen(id) * NT && p != 4'b0000 && top(p) > int'(id)) begin
                id = 2'(top(p)); p[id] = 1'b0; el = 0;
            end else begin
                el++;
                if (el == nlen(id) * NT + GT) begin b = 1'b0; el = 0; end
            end
            p = p | req;
            m_pend = p; m_busy = b; m_id = id; m_el = el;
        end
    end

    // Directed expectations, set by the stimulus and consumed at the next falling edge.
    bit          h_en = 1'b0;
    string       h_nm = "";
    logic [21:0] h_nd = '0;
    logic        h_te = 1'b0;
    logic        h_du = 1'b0;
    logic [3:0]  h_pe = '0;
    int          h_aid = -1;

    int n_tot  = 0;
    int n_pass = 0;

    always begin
        logic [21:0] e_nd;
        logic        e_te;
        @(negedge clk);
        e_te = m_busy && (m_el < nlen(m_id) * NT);
        e_nd = e_te ? 22'(ROM[m_id][m_el / NT]) : 22'd0;
        n_tot++;
        if (note_div !== e_nd || tone_en !== e_te || duck !== m_busy || pending !== m_pend ||
            (m_busy && active_id !== m_id))
            $display("FAIL model @%0t: got nd=%0d te=%b duck=%b pend=%b id=%0d; want nd=%0d te=%b duck=%b pend=%b id=%0d",
                     $time, note_div, tone_en, duck, pending, active_id, e_nd, e_te, m_busy, m_pend, m_id);
        else
            n_pass++;
        if (h_en) begin
            n_tot++;
            if (note_div !== h_nd || tone_en !== h_te || duck !== h_du || pending !== h_pe ||
                (h_aid >= 0 && active_id !== 2'(h_aid)))
                $display("FAIL %s @%0t: got nd=%0d te=%b duck=%b pend=%b id=%0d; want nd=%0d te=%b duck=%b pend=%b id=%0d",
                         h_nm, $time, note_div, tone_en, duck, pending, active_id, h_nd, h_te, h_du, h_pe, h_aid);
            else
                n_pass++;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
        h_en = 1'b0;
    endtask

    task automatic hx(input string nm, input int nd, input bit te, input bit du,
                      input logic [3:0] pe, input int aid);
        h_nm = nm; h_nd = 22'(nd); h_te = te; h_du = du; h_pe = pe; h_aid = aid;
        h_en = 1'b1;
    endtask

    initial begin
        // Reset
        step; step;
        hx("reset", 0, 0, 0, 4'b0000, 0);
        step; rst_n = 1'b1;

        // Single bullet
        step; req = 4'b0001;
        step; req = 4'b0000; hx("t1 pend", 0, 0, 0, 4'b0001, -1);
        step; hx("t1 note0", 90000, 1, 1, 4'b0000, 0);
        repeat (3) step;
        step; hx("t1 note1", 75000, 1, 1, 4'b0000, 0);
        repeat (3) step;
        step; hx("t1 gap", 0, 0, 1, 4'b0000, 0);
        step;
        step; hx("t1 idle", 0, 0, 0, 4'b0000, -1);
        repeat (5) step;

        // Simultaneous id2 + id0
        step; req = 4'b0101;
        step; req = 4'b0000; hx("t2 pend", 0, 0, 0, 4'b0101, -1);
        step; hx("t2 id2", 191571, 1, 1, 4'b0001, 2);
        repeat (17) step;
        step; hx("t2 idle", 0, 0, 0, 4'b0001, -1);
        step; hx("t2 id0", 90000, 1, 1, 4'b0000, 0);
        repeat (15) step;

        // Re-request of the playing id
        step; req = 4'b0010;
        step; req = 4'b0000;
        step; hx("t3 play", 151515, 1, 1, 4'b0000, 1);
        step; req = 4'b0010;
        step; req = 4'b0000; hx("t3 repend", 151515, 1, 1, 4'b0010, 1);
        repeat (7) step;
        step; hx("t3 idle", 0, 0, 0, 4'b0010, -1);
        step; hx("t3 replay", 151515, 1, 1, 4'b0000, 1);
        repeat (15) step;

        // Higher-priority request mid-id0
        step; req = 4'b0001;
        step; req = 4'b0000;
        step; step; req = 4'b1000;
        step; req = 4'b0000; hx("t4 pend", 90000, 1, 1, 4'b1000, 0);
        step;
        if (PRE) hx("t4 preempt", 255102, 1, 1, 4'b0000, 3);
        else     hx("t4 nopreempt", 90000, 1, 1, 4'b1000, 0);
        repeat (40) step;

        // Abort via sfx_en
        step; req = 4'b0010;
        step; req = 4'b0000;
        step; step; req = 4'b0010;
        step; req = 4'b0000; hx("t5 pend", 151515, 1, 1, 4'b0010, 1);
        sfx_en = 1'b0; req = 4'b0100;
        step; req = 4'b0000; hx("t5 abort", 0, 0, 0, 4'b0000, -1);
        req = 4'b1000;
        step; req = 4'b0000; hx("t5 ignore", 0, 0, 0, 4'b0000, -1);
        step; sfx_en = 1'b1;
        repeat (6) step;

        // Reset mid-note, asserted between clock edges
        step; req = 4'b1000;
        step; req = 4'b0000;
        step; step;
        rst_n = 1'b0; hx("t6 async rst", 0, 0, 0, 4'b0000, 0);
        step; step; rst_n = 1'b1;
        repeat (3) step;
        hx("t6 no resume", 0, 0, 0, 4'b0000, -1);
        repeat (10) step;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
